// File: rtl/jtframe_mixer_fader.sv
// rtl/jtframe_mixer_fader.sv - per-channel gain ramp controller with peak limiter for the 4-channel mixer
module jtframe_mixer_fader #(
  parameter logic [7:0] DEFAULT_GAIN = 8'h10,
  parameter int         RATE_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       wr,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  input  logic       peak,
  output logic [7:0] gain0,
  output logic [7:0] gain1,
  output logic [7:0] gain2,
  output logic [7:0] gain3,
  output logic       busy,
  output logic       settled
);

  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3} state_t;

  state_t            state, state_nx;
  logic [7:0]        target [4];
  logic [7:0]        gain   [4];
  logic [RATE_W-1:0] rate, div;
  logic [7:0]        step;
  logic              lim_en, peak_l;
  logic              snap, tick, upd;
  logic [1:0]        ch;

  // Snap is a strobe carried by a ctrl write; it is never stored.
  assign snap = wr && (addr == 3'd6) && din[1];
  assign tick = cen && (state == IDLE) && (div == '0);

  // One step of a channel: limiter decay, or a bounded move toward the target.
  function automatic logic [7:0] next_gain(input logic [7:0] g, input logic [7:0] t,
                                           input logic [7:0] s, input logic lim);
    logic [8:0] g9, t9, s9;
    logic [7:0] r;
    g9 = {1'b0, g};
    t9 = {1'b0, t};
    s9 = {1'b0, s};
    r  = g;
    if (lim)          r = (g == 8'd0) ? 8'd0 : g - 8'd1;
    else if (g9 < t9) r = (s9 < t9 - g9) ? 8'(g9 + s9) : t;
    else if (g9 > t9) r = (s9 < g9 - t9) ? 8'(g9 - s9) : t;
    return r;
  endfunction

  // State register of the channel scanner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Scanner sequencing: each busy cen updates one channel, snap aborts the scan.
  always_comb begin
    state_nx = state;
    upd      = 1'b0;
    ch       = 2'd0;
    case (state)
      IDLE: if (tick) state_nx = S0;
      S0:   if (cen) begin state_nx = S1;   upd = 1'b1; ch = 2'd0; end
      S1:   if (cen) begin state_nx = S2;   upd = 1'b1; ch = 2'd1; end
      S2:   if (cen) begin state_nx = S3;   upd = 1'b1; ch = 2'd2; end
      S3:   if (cen) begin state_nx = IDLE; upd = 1'b1; ch = 2'd3; end
      default: state_nx = IDLE;
    endcase
    if (snap) begin
      state_nx = IDLE;
      upd      = 1'b0;
    end
  end

  // Tick divider: counts idle cen pulses; it freezes while a scan runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          div <= '0;
    else if (snap)                    div <= rate;
    else if (cen && state == IDLE)    div <= (div == '0) ? rate : div - 1'b1;
  end

  // CPU-visible registers; writes are accepted on any clk edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) target[i] <= DEFAULT_GAIN;
      rate   <= '0;
      step   <= 8'd1;
      lim_en <= 1'b0;
    end else if (wr) begin
      case (addr)
        3'd0, 3'd1, 3'd2, 3'd3: target[addr[1:0]] <= din;
        3'd4: rate   <= din[RATE_W-1:0];
        3'd5: step   <= (din == 8'd0) ? 8'd1 : din;
        3'd6: lim_en <= din[0];
        default: ;
      endcase
    end
  end

  // Live gains: snap jumps to the targets, otherwise the scanned channel steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) gain[i] <= DEFAULT_GAIN;
    end else if (snap) begin
      for (int i = 0; i < 4; i++) gain[i] <= target[i];
    end else if (upd) begin
      gain[ch] <= next_gain(gain[ch], target[ch], step, lim_en && peak_l);
    end
  end

  // Peak latch: a new peak outranks the end-of-scan clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        peak_l <= 1'b0;
    else if (snap)                  peak_l <= 1'b0;
    else if (cen && peak)           peak_l <= 1'b1;
    else if (cen && state == S3)    peak_l <= 1'b0;
  end

  assign gain0   = gain[0];
  assign gain1   = gain[1];
  assign gain2   = gain[2];
  assign gain3   = gain[3];
  assign busy    = (state != IDLE);
  assign settled = (gain[0] == target[0]) && (gain[1] == target[1]) &&
                   (gain[2] == target[2]) && (gain[3] == target[3]);

endmodule

// File: tb/tb_jtframe_mixer_fader.sv
// tb/tb_jtframe_mixer_fader.sv - self-checking bench for jtframe_mixer_fader
module tb_jtframe_mixer_fader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       wr = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'd0;
  logic       peak = 1'b0;
  logic [7:0] gain0, gain1, gain2, gain3;
  logic       busy, settled;

  int checks = 0;
  int errors = 0;

  jtframe_mixer_fader dut (
    .clk(clk), .rst(rst), .cen(cen), .wr(wr), .addr(addr), .din(din), .peak(peak),
    .gain0(gain0), .gain1(gain1), .gain2(gain2), .gain3(gain3),
    .busy(busy), .settled(settled)
  );

  always #5 clk = ~clk;

  // Reference model: registers plus "which channel is next" (-1 when idle)
  // and the number of idle cen pulses still to wait before a scan.
  int m_tgt[4], m_gain[4];
  int m_rate, m_step, m_lim, m_latch, m_cnt, m_scan;

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] din;
    logic       cen;
    logic       peak;
    logic [7:0] g0;
    logic       busy;
    logic       settled;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_tgt[i] = 16; m_gain[i] = 16; end
    m_rate = 0; m_step = 1; m_lim = 0; m_latch = 0; m_cnt = 0; m_scan = -1;
  endtask

  task automatic model_edge();
    int  ng[4];
    int  nscan, ncnt, nlatch, c, g, t, d;
    bit  snap;
    for (int i = 0; i < 4; i++) ng[i] = m_gain[i];
    nscan = m_scan; ncnt = m_cnt; nlatch = m_latch;
    snap = wr && addr == 3'd6 && din[1];
    if (snap) begin
      for (int i = 0; i < 4; i++) ng[i] = m_tgt[i];
      nscan = -1; nlatch = 0; ncnt = m_rate;
    end else begin
      if (cen) begin
        if (m_scan < 0) begin
          if (m_cnt == 0) begin nscan = 0; ncnt = m_rate; end
          else ncnt = m_cnt - 1;
        end else begin
          c = m_scan; g = m_gain[c]; t = m_tgt[c];
          if (m_lim != 0 && m_latch != 0) ng[c] = (g > 0) ? g - 1 : 0;
          else if (g < t) begin d = t - g; ng[c] = g + ((m_step < d) ? m_step : d); end
          else if (g > t) begin d = g - t; ng[c] = g - ((m_step < d) ? m_step : d); end
          nscan = (m_scan == 3) ? -1 : m_scan + 1;
        end
      end
      if (cen && peak)              nlatch = 1;
      else if (cen && m_scan == 3)  nlatch = 0;
    end
    if (wr) begin
      case (addr)
        3'd0, 3'd1, 3'd2, 3'd3: m_tgt[addr] = din;
        3'd4: m_rate = din;
        3'd5: m_step = (din == 0) ? 1 : din;
        3'd6: m_lim = din[0];
        default: ;
      endcase
    end
    for (int i = 0; i < 4; i++) m_gain[i] = ng[i];
    m_scan = nscan; m_cnt = ncnt; m_latch = nlatch;
  endtask

  task automatic check_model();
    bit s;
    s = 1;
    for (int i = 0; i < 4; i++) if (m_gain[i] != m_tgt[i]) s = 0;
    chk("model gain0", gain0, m_gain[0]);
    chk("model gain1", gain1, m_gain[1]);
    chk("model gain2", gain2, m_gain[2]);
    chk("model gain3", gain3, m_gain[3]);
    chk("model busy", busy, (m_scan >= 0) ? 1 : 0);
    chk("model settled", settled, s);
  endtask

  // One clk edge with the given inputs, model advanced and outputs compared.
  task automatic cyc(input logic w, input logic [2:0] a, input logic [7:0] d,
                     input logic c, input logic p);
    wr = w; addr = a; din = d; cen = c; peak = p;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
    wr = 1'b0; cen = 1'b0; peak = 1'b0;
  endtask

  // Free-running cen until busy reaches the wanted level; n counts cen pulses.
  task automatic run_until(input logic want, input int max, output int n);
    n = 0;
    while (busy != want && n < max) begin
      cyc(1'b0, 3'd0, 8'd0, 1'b1, 1'b0);
      n++;
    end
    if (busy != want) chk("wait busy timeout", busy, want);
  endtask

  function automatic void add(input logic w, input logic [2:0] a, input logic [7:0] d,
                              input logic c, input logic [7:0] g0, input logic b,
                              input logic s);
    vec_t v;
    v.wr = w; v.addr = a; v.din = d; v.cen = c; v.peak = 1'b0;
    v.g0 = g0; v.busy = b; v.settled = s;
    tbl.push_back(v);
  endfunction

  initial begin
    int n;
    logic [7:0] ramp [3];
    ramp[0] = 8'h14; ramp[1] = 8'h18; ramp[2] = 8'h1A;

    // Idle scan at rate 0, then step=4 and target0=1A ramp over three scans.
    add(0, 3'd0, 8'h00, 1, 8'h10, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 3'd0, 8'h00, 1, 8'h10, 1, 1);
    add(0, 3'd0, 8'h00, 1, 8'h10, 0, 1);
    add(1, 3'd5, 8'h04, 0, 8'h10, 0, 1);
    add(1, 3'd0, 8'h1A, 0, 8'h10, 0, 0);
    for (int s = 0; s < 3; s++) begin
      add(0, 3'd0, 8'h00, 1, (s == 0) ? 8'h10 : ramp[s-1], 1, 0);
      for (int i = 0; i < 3; i++) add(0, 3'd0, 8'h00, 1, ramp[s], 1, (s == 2) ? 1'b1 : 1'b0);
      add(0, 3'd0, 8'h00, 1, ramp[s], 0, (s == 2) ? 1'b1 : 1'b0);
    end

    model_reset();
    #23 rst = 1'b0;
    #1;
    chk("reset gain0", gain0, 8'h10);
    chk("reset gain3", gain3, 8'h10);
    chk("reset busy", busy, 0);
    chk("reset settled", settled, 1);

    foreach (tbl[i]) begin
      cyc(tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].cen, tbl[i].peak);
      chk($sformatf("tbl[%0d] gain0", i), gain0, tbl[i].g0);
      chk($sformatf("tbl[%0d] busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl[%0d] settled", i), settled, tbl[i].settled);
    end

    // Large step, slower rate: one-scan drop and scan spacing.
    cyc(1, 3'd5, 8'h20, 0, 0);
    cyc(1, 3'd1, 8'h00, 0, 0);
    cyc(1, 3'd4, 8'h03, 0, 0);
    run_until(1'b1, 20, n);
    chk("scan start latency ok", (n >= 1 && n <= 4) ? 1 : 0, 1);
    run_until(1'b0, 20, n);
    chk("busy length", n, 4);
    chk("gain1 one scan", gain1, 8'h00);
    run_until(1'b1, 20, n);
    chk("idle spacing", n, 4);
    run_until(1'b0, 20, n);

    // Limiter: snap everything to 10 with lim_en, then one peak.
    for (int i = 0; i < 4; i++) cyc(1, 3'(i), 8'h10, 0, 0);
    cyc(1, 3'd6, 8'h03, 0, 0);
    chk("snap idle", busy, 0);
    cyc(0, 3'd0, 8'h00, 1, 1);
    run_until(1'b1, 20, n);
    run_until(1'b0, 20, n);
    chk("lim gain0", gain0, 8'h0F);
    chk("lim gain1", gain1, 8'h0F);
    chk("lim gain2", gain2, 8'h0F);
    chk("lim gain3", gain3, 8'h0F);
    run_until(1'b1, 20, n);
    run_until(1'b0, 20, n);
    chk("recover gain0", gain0, 8'h10);
    chk("recover gain3", gain3, 8'h10);

    // Snap in the middle of a scan.
    cyc(1, 3'd2, 8'h40, 0, 0);
    run_until(1'b1, 20, n);
    cyc(0, 3'd0, 8'h00, 1, 0);
    cyc(1, 3'd6, 8'h02, 1, 0);
    chk("snap gain2", gain2, 8'h40);
    chk("snap busy", busy, 0);
    run_until(1'b1, 20, n);
    chk("snap divider reload", n, 4);

    // Asynchronous reset while ramping, away from any clk edge.
    cyc(1, 3'd5, 8'h01, 0, 0);
    cyc(1, 3'd3, 8'h80, 0, 0);
    cyc(1, 3'd4, 8'h00, 0, 0);
    run_until(1'b0, 20, n);
    run_until(1'b1, 20, n);
    cyc(0, 3'd0, 8'h00, 1, 0);
    cyc(0, 3'd0, 8'h00, 1, 0);
    chk("pre-reset ramping", settled, 0);
    #2 rst = 1'b1;
    #1;
    chk("async gain3", gain3, 8'h10);
    chk("async gain2", gain2, 8'h10);
    chk("async busy", busy, 0);
    chk("async settled", settled, 1);
    model_reset();
    #14 rst = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic       w;
      logic [2:0] a;
      logic [7:0] d;
      w = ($urandom_range(0, 7) == 0);
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom_range(0, 255));
      if (a == 3'd4) d = 8'($urandom_range(0, 3));
      if (a == 3'd6 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
      cyc(w, a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
